// File: rtl/uart_pkg.sv
// Shared definitions for the UART/ALU receive sequencer: state encoding,
// default widths and the opcode set understood by the ALU.
package uart_pkg;

    localparam int NB_BIT_DEF = 8;
    localparam int NB_OP_DEF  = 6;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

    // A frame is in flight from the opcode byte until the transmitter finishes.
    function automatic logic is_busy_state(input state_t s);
        return (s == ST_EXEC) || (s == ST_SEND) || (s == ST_WAIT_TX);
    endfunction

endpackage

// File: rtl/uart_if_timer.sv
// Inter-byte timeout counter for uart_alu_if; only instantiated when
// UART_IF_TIMEOUT_EN is defined.
module uart_if_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expire_o
);

    localparam int NB_CNT = $clog2(TIMEOUT_CYCLES);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

    logic [NB_CNT-1:0] cnt_q;
    logic [NB_CNT-1:0] cnt_d;

    // Saturate at the last value so a stalled count can never wrap.
    always_comb begin
        if (clear_i) begin
            cnt_d = {NB_CNT{1'b0}};
        end else if (count_en_i && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + NB_CNT'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= {NB_CNT{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = count_en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_alu_if.sv
// Collects operand A, operand B and opcode bytes from the UART receiver, drives
// the ALU and hands the result to the transmitter. Option: UART_IF_TIMEOUT_EN.
module uart_alu_if
    import uart_pkg::*;
#(
    parameter int NB_BIT         = NB_BIT_DEF,
    parameter int NB_OP          = NB_OP_DEF,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rx_done_tick_i,
    input  logic [NB_BIT-1:0] rx_data_i,
    input  logic [NB_BIT-1:0] alu_result_i,
    input  logic              tx_done_tick_i,
    output logic [NB_BIT-1:0] data_a_o,
    output logic [NB_BIT-1:0] data_b_o,
    output logic [NB_OP-1:0]  data_op_o,
    output logic              tx_start_o,
    output logic [NB_BIT-1:0] tx_data_o,
    output logic              busy_o,
    output logic              timeout_o
);

    state_t            state_q, state_d;
    logic [NB_BIT-1:0] data_a_q, data_a_d;
    logic [NB_BIT-1:0] data_b_q, data_b_d;
    logic [NB_OP-1:0]  data_op_q, data_op_d;
    logic [NB_BIT-1:0] tx_data_q, tx_data_d;
    logic              timeout_q, timeout_d;
    logic              timer_clear_s;
    logic              timer_en_s;
    logic              expire_s;

    assign timer_en_s = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);

    // A byte arriving in the expiry cycle takes priority over the timeout.
    always_comb begin
        state_d       = state_q;
        data_a_d      = data_a_q;
        data_b_d      = data_b_q;
        data_op_d     = data_op_q;
        tx_data_d     = tx_data_q;
        timeout_d     = 1'b0;
        timer_clear_s = 1'b0;
        case (state_q)
            ST_WAIT_A: begin
                if (rx_done_tick_i) begin
                    data_a_d      = rx_data_i;
                    timer_clear_s = 1'b1;
                    state_d       = ST_WAIT_B;
                end else begin
                    state_d = ST_WAIT_A;
                end
            end
            ST_WAIT_B: begin
                if (rx_done_tick_i) begin
                    data_b_d      = rx_data_i;
                    timer_clear_s = 1'b1;
                    state_d       = ST_WAIT_OP;
                end else if (expire_s) begin
                    timeout_d = 1'b1;
                    state_d   = ST_WAIT_A;
                end else begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_OP: begin
                if (rx_done_tick_i) begin
                    data_op_d = rx_data_i[NB_OP-1:0];
                    state_d   = ST_EXEC;
                end else if (expire_s) begin
                    timeout_d = 1'b1;
                    state_d   = ST_WAIT_A;
                end else begin
                    state_d = ST_WAIT_OP;
                end
            end
            ST_EXEC: begin
                tx_data_d = alu_result_i;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done_tick_i) begin
                    state_d = ST_WAIT_A;
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_WAIT_A;
            data_a_q  <= {NB_BIT{1'b0}};
            data_b_q  <= {NB_BIT{1'b0}};
            data_op_q <= {NB_OP{1'b0}};
            tx_data_q <= {NB_BIT{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            data_op_q <= data_op_d;
            tx_data_q <= tx_data_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef UART_IF_TIMEOUT_EN
    uart_if_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (timer_clear_s),
        .count_en_i(timer_en_s),
        .expire_o  (expire_s)
    );
`else
    logic unused_cfg;
    assign expire_s   = 1'b0;
    assign unused_cfg = timer_clear_s ^ timer_en_s ^ (TIMEOUT_CYCLES < 2);
`endif

    assign data_a_o   = data_a_q;
    assign data_b_o   = data_b_q;
    assign data_op_o  = data_op_q;
    assign tx_data_o  = tx_data_q;
    assign timeout_o  = timeout_q;
    assign tx_start_o = (state_q == ST_SEND);
    assign busy_o     = is_busy_state(state_q);

endmodule

// File: tb/tb_uart_alu_if.sv
// Scoreboard bench for uart_alu_if: stimulus pushes expected frame results,
// a negedge monitor pops them on every tx_start pulse.
module tb_uart_alu_if;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic [7:0] alu_result;
    logic       tx_done_tick;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] data_op;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       timeout;

    always #5 clk = ~clk;

    uart_alu_if #(
        .NB_BIT(8),
        .NB_OP(6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .rx_done_tick_i(rx_done_tick),
        .rx_data_i     (rx_data),
        .alu_result_i  (alu_result),
        .tx_done_tick_i(tx_done_tick),
        .data_a_o      (data_a),
        .data_b_o      (data_b),
        .data_op_o     (data_op),
        .tx_start_o    (tx_start),
        .tx_data_o     (tx_data),
        .busy_o        (busy),
        .timeout_o     (timeout)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   frames_sent = 0;
    int   pulses_seen = 0;
    int   exp_to_cyc = -1;

    // Stand-in ALU; the same rules give the expected result of each frame.
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return $unsigned($signed(a) >>> b[2:0]);
            6'h02:   return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_model(data_a, data_b, data_op);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every tx_start must match the oldest outstanding frame.
    always @(negedge clk) begin
        exp_t e;
        if (tx_start === 1'b1) begin
            pulses_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_tx_start", 32'(tx_start), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e.res));
                check("data_a", 32'(data_a), 32'(e.a));
                check("data_b", 32'(data_b), 32'(e.b));
                check("data_op", 32'(data_op), 32'(e.op));
                check("tx_start_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        check("timeout", 32'(timeout), 32'(cyc == exp_to_cyc));
    end

    // One clock of input drive; busy_exp >= 0 also checks busy mid-cycle.
    task automatic drive(input logic rx, input logic [7:0] d, input logic txd, input int busy_exp);
        rx_done_tick = rx;
        rx_data      = d;
        tx_done_tick = txd;
        @(negedge clk);
        if (busy_exp >= 0) check("busy", 32'(busy), 32'(busy_exp));
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                              input int g1, input int g2, input int txdelay, input logic simul);
        int n;
        exp_t e;
        drive(1'b1, a, 1'b0, 0);
        repeat (g1) drive(1'b0, 8'($urandom), 1'b0, 0);
        drive(1'b1, b, 1'b0, 0);
        repeat (g2) drive(1'b0, 8'($urandom), 1'b0, 0);
        n = cyc;
        e.a = a; e.b = b; e.op = opb[5:0];
        e.res = alu_model(a, b, opb[5:0]);
        e.cyc = n + 2;
        sb_q.push_back(e);
        frames_sent++;
        drive(1'b1, opb, 1'b0, 0);
        // Bytes arriving before tx_done are junk and must be dropped.
        for (int k = 1; k < txdelay; k++)
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1);
        drive(simul, 8'($urandom), 1'b1, 1);
        drive(1'b0, 8'h00, 1'b0, 0);
    endtask

    task automatic pulse_reset_and_check();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_data_a", 32'(data_a), 32'd0);
        check("rst_data_b", 32'(data_b), 32'd0);
        check("rst_data_op", 32'(data_op), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [8];
        logic [1:0] hi;
        int n;
        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        rx_data      = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        pulse_reset_and_check();

        // Directed frames; the first ends with rx and tx_done coincident.
        send_frame(8'h05, 8'h03, 8'h20, 0, 0, 3, 1'b1);
        send_frame(8'hFF, 8'h01, 8'h22, 1, 2, 6, 1'b0);
        send_frame(8'h0F, 8'h30, 8'hE5, 0, 1, 4, 1'b1);

        // Reset mid-frame discards operand A.
        drive(1'b1, 8'h11, 1'b0, 0);
        drive(1'b0, 8'h00, 1'b0, 0);
        pulse_reset_and_check();
        send_frame(8'h02, 8'h02, 8'h20, 0, 0, 3, 1'b0);

`ifdef UART_IF_TIMEOUT_EN
        // Silence after byte A: timeout 16 cycles after entering WAIT_B.
        n = cyc;
        exp_to_cyc = n + 17;
        drive(1'b1, 8'hA7, 1'b0, 0);
        repeat (20) drive(1'b0, 8'h00, 1'b0, 0);
        send_frame(8'h09, 8'h04, 8'h22, 0, 0, 3, 1'b0);
        // Silence after byte B.
        drive(1'b1, 8'h5A, 1'b0, 0);
        n = cyc;
        exp_to_cyc = n + 17;
        drive(1'b1, 8'hA5, 1'b0, 0);
        repeat (20) drive(1'b0, 8'h00, 1'b0, 0);
        exp_to_cyc = -1;
        // Bytes landing exactly in the expiry cycle are accepted.
        send_frame(8'h30, 8'h0C, 8'h26, 15, 15, 3, 1'b0);
`else
        // Without the timeout a partial frame waits indefinitely.
        send_frame(8'h30, 8'h0C, 8'h26, 40, 40, 3, 1'b0);
`endif

        for (int i = 0; i < 20; i++) begin
            hi = 2'($urandom_range(0, 3));
            send_frame(8'($urandom), 8'($urandom), {hi, ops[$urandom_range(0, 7)]},
                       $urandom_range(0, 4), $urandom_range(0, 4),
                       $urandom_range(3, 8), 1'($urandom_range(0, 1)));
        end

        repeat (5) drive(1'b0, 8'h00, 1'b0, 0);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("tx_start_count", 32'(pulses_seen), 32'(frames_sent));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
